multicycle_main_ctrl: RTL and testbench
=======================================

Name: multicycle_main_ctrl

Overview:
Multi-cycle successor to the single-cycle main decoder for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It talks to a variable-latency memory through a req/ready handshake and optionally sequences multi-cycle M-extension ops. Decoded control fields are registered and held for the whole instruction. Halt, illegal-instruction and memory-timeout conditions are reported as sticky flags.

Parameters:
ENABLE_M, 1, 1 = opcode 0110011 with funct7=0000001 is a legal M-op; 0 = illegal.
MUL_LATENCY, 2, EXEC cycles for MUL* (funct3[2]=0); a value of 0 is treated as 1.
DIV_LATENCY, 32, EXEC cycles for DIV*/REM* (funct3[2]=1); a value of 0 is treated as 1.
MEM_TIMEOUT, 255, max cycles without i_memReady during one request before trap; 0 disables the timeout.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_opcode  in  7  opcode of the latched instruction register
i_funct3  in  3  funct3 of the latched instruction register
i_funct7  in  7  funct7 of the latched instruction register
i_memReady  in  1  memory completes the current request this cycle
o_memReq  out  1  memory request
o_memWrite  out  1  request is a store
o_memIsFetch  out  1  request is an instruction fetch
o_irWrite  out  1  load the instruction register
o_pcWrite  out  1  commit next PC
o_regWrite  out  1  register-file write strobe
o_ALUSrc  out  1  registered control field
o_immSrc  out  3  registered control field
o_resultSrc  out  2  registered control field
o_ALUOp  out  2  registered control field
o_branch / o_jal / o_jalr  out  1 each  registered control fields
o_isLoadSigned  out  1  registered control field
o_mulDivStart  out  1  one-cycle start strobe to the mul/div unit
o_halt / o_illegal / o_memTimeout  out  1 each  sticky status flags
o_state  out  3  current state, for debug

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- Async reset: state RST, every output and counter 0. Reset mid-request drops o_memReq immediately.
- RST: all strobes 0; always goes to FETCH on the next edge.
- FETCH:
  - o_memReq=1, o_memIsFetch=1.
  - On i_memReady: o_irWrite=1 for that cycle, then go to DECODE.
- DECODE (1 cycle): register the control fields from i_opcode/funct3/funct7. Fields read {ALUOp,ALUSrc,immSrc,resultSrc}:
  - load 0000011: 00,1,000,01
  - op-imm 0010011: 10,1,010,00 if funct3[1:0]=01, else 10,1,001,00
  - store 0100011: 00,1,011,00
  - R 0110011: 10,0,000,00
  - LUI/AUIPC 0?10111: 00,0,100,10
  - branch 1100011: 01,0,101,00 with branch=1
  - jalr 1100111: 00,0,110,11 with jalr=1
  - jal 1101111: 00,0,111,11 with jal=1
  - o_isLoadSigned = funct3[2].
- DECODE next state:
  - 1110011 with funct3=000 -> HALT, o_halt=1.
  - 1110011 with funct3!=000, or opcode 0000000 -> nop: o_pcWrite=1, go to FETCH.
  - Any other unlisted opcode, or an R-type funct7 other than 0000000/0100000 (plus 0000001 when ENABLE_M=1) -> TRAP, o_illegal=1.
  - Otherwise -> EXEC.
- EXEC:
  - Normal ops: 1 cycle.
  - M-op: o_mulDivStart=1 on the first EXEC cycle only; EXEC lasts the applicable latency, counted by an internal down-counter.
  - Exit: load/store -> MEM; branch asserts o_pcWrite=1 in its last EXEC cycle and goes to FETCH; everything else -> WB.
- MEM:
  - o_memReq=1; o_memWrite=1 for a store.
  - On i_memReady: load -> WB; store asserts o_pcWrite=1 that cycle and goes to FETCH.
- WB (1 cycle): o_regWrite=1 and o_pcWrite=1 together, then go to FETCH.
- Handshake:
  - o_memReq, o_memWrite and o_memIsFetch are combinational from state only; they stay stable until i_memReady.
  - i_memReady outside FETCH/MEM is ignored.
  - i_memReady in the first request cycle gives zero wait states.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle the request is pending without ready.
  - When the count equals MEM_TIMEOUT with ready still low: go to TRAP, o_memTimeout=1, o_memReq drops.
  - If ready arrives in the same cycle the limit is reached, the ready wins.
- HALT and TRAP are terminal until reset. All strobes are 0 there; flags stay held.
- Registered control fields hold from the edge leaving DECODE until the next DECODE.
- Latency with zero-wait memory: ALU/LUI/JAL 4 cycles; load 5; store 4; branch 3; M-op 3+latency.

Test Plan:
- Reset release, ALU add with ready=1 always -> states 1,2,3,5; o_regWrite and o_pcWrite both 1 only in cycle 4; ALUOp=10, ALUSrc=0.
- Load with fetch ready after 3 waits and MEM ready after 2 -> o_memReq held 4 and 3 cycles; o_irWrite single pulse; o_resultSrc=01; total 10 cycles.
- Store with ready=1 -> o_memWrite=1 in MEM only; o_pcWrite in MEM cycle; o_regWrite never 1.
- ENABLE_M=1, DIV_LATENCY=32, funct7=0000001, funct3=100 -> o_mulDivStart one pulse; EXEC lasts 32 cycles; then WB.
- ENABLE_M=0 with the same op -> TRAP at cycle 3, o_illegal=1; o_memReq stays 0 for 50 further cycles.
- MEM_TIMEOUT=4, ready held low in FETCH -> TRAP after 4 cycles, o_memTimeout=1. Separately: ecall -> HALT, o_halt=1. Reset mid-MEM -> o_memReq 0 immediately, state 0.

Source files
------------

// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle main controller for the RV32I core. Each instruction moves
// through FETCH, DECODE, EXEC, optional MEM and WB. Memory is reached
// through a req/ready handshake that has a timeout. M-extension ops hold
// EXEC for a configurable number of cycles.
// Ports:
//   i_clk, i_rst_n                 clock and async active-low reset
//   i_opcode/i_funct3/i_funct7     fields of the latched instruction register
//   i_memReady                     memory completes the current request
//   o_memReq/o_memWrite/o_memIsFetch  request qualifiers, decoded from state only
//   o_irWrite/o_pcWrite/o_regWrite/o_mulDivStart  single-cycle strobes
//   o_ALUSrc..o_isLoadSigned       control fields, registered in DECODE
//   o_halt/o_illegal/o_memTimeout  sticky status flags
//   o_state                        current state, for debug
module multicycle_main_ctrl #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_memReady,
  output logic       o_memReq,
  output logic       o_memWrite,
  output logic       o_memIsFetch,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic       o_regWrite,
  output logic       o_ALUSrc,
  output logic [2:0] o_immSrc,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_ALUOp,
  output logic       o_branch,
  output logic       o_jal,
  output logic       o_jalr,
  output logic       o_isLoadSigned,
  output logic       o_mulDivStart,
  output logic       o_halt,
  output logic       o_illegal,
  output logic       o_memTimeout,
  output logic [2:0] o_state
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned MUL_LAT = (MUL_LATENCY == 0) ? 1 : MUL_LATENCY;
  localparam int unsigned DIV_LAT = (DIV_LATENCY == 0) ? 1 : DIV_LATENCY;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   exec_q, exec_d;
  logic               exec_first_q, exec_first_d;
  logic               halt_q, halt_d, illegal_q, illegal_d, memtmo_q, memtmo_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               alu_src_q, alu_src_d;
  logic [2:0]         imm_src_q, imm_src_d;
  logic [1:0]         result_src_q, result_src_d;
  logic               branch_q, branch_d, jal_q, jal_d, jalr_q, jalr_d;
  logic               signed_q, signed_d;
  logic               is_load_q, is_load_d, is_store_q, is_store_d, is_mop_q, is_mop_d;

  // Combinational decode of the instruction register
  logic [1:0]       dec_alu_op;
  logic             dec_alu_src;
  logic [2:0]       dec_imm;
  logic [1:0]       dec_res;
  logic             dec_br, dec_jal, dec_jalr, dec_load, dec_store, dec_mop;
  logic             dec_halt, dec_nop, dec_illegal;
  logic [CNT_W-1:0] dec_lat_m1;
  logic             tmo_hit;

  always_comb begin
    dec_alu_op  = 2'b00;
    dec_alu_src = 1'b0;
    dec_imm     = 3'b000;
    dec_res     = 2'b00;
    dec_br      = 1'b0;
    dec_jal     = 1'b0;
    dec_jalr    = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_mop     = 1'b0;
    dec_halt    = 1'b0;
    dec_nop     = 1'b0;
    dec_illegal = 1'b0;
    case (i_opcode)
      7'b0000011: begin
        dec_alu_src = 1'b1;
        dec_res     = 2'b01;
        dec_load    = 1'b1;
      end
      7'b0010011: begin
        dec_alu_op  = 2'b10;
        dec_alu_src = 1'b1;
        // shift-immediates use the 5-bit shamt immediate format
        dec_imm     = (i_funct3[1:0] == 2'b01) ? 3'b010 : 3'b001;
      end
      7'b0100011: begin
        dec_alu_src = 1'b1;
        dec_imm     = 3'b011;
        dec_store   = 1'b1;
      end
      7'b0110011: begin
        dec_alu_op = 2'b10;
        if (i_funct7 == 7'b0000000 || i_funct7 == 7'b0100000) begin
          dec_mop = 1'b0;
        end else if (ENABLE_M && i_funct7 == 7'b0000001) begin
          dec_mop = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0010111, 7'b0110111: begin
        dec_imm = 3'b100;
        dec_res = 2'b10;
      end
      7'b1100011: begin
        dec_alu_op = 2'b01;
        dec_imm    = 3'b101;
        dec_br     = 1'b1;
      end
      7'b1100111: begin
        dec_imm  = 3'b110;
        dec_res  = 2'b11;
        dec_jalr = 1'b1;
      end
      7'b1101111: begin
        dec_imm = 3'b111;
        dec_res = 2'b11;
        dec_jal = 1'b1;
      end
      7'b1110011: begin
        if (i_funct3 == 3'b000) dec_halt = 1'b1;
        else                    dec_nop  = 1'b1;
      end
      7'b0000000: dec_nop = 1'b1;
      default:    dec_illegal = 1'b1;
    endcase
    dec_lat_m1 = i_funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  end

  // Limit reached on this cycle's request with ready still low
  assign tmo_hit = (MEM_TIMEOUT != 0) && !i_memReady &&
                   (tmo_q == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state and strobe logic
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    exec_d       = exec_q;
    exec_first_d = 1'b0;
    halt_d       = halt_q;
    illegal_d    = illegal_q;
    memtmo_d     = memtmo_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    imm_src_d    = imm_src_q;
    result_src_d = result_src_q;
    branch_d     = branch_q;
    jal_d        = jal_q;
    jalr_d       = jalr_q;
    signed_d     = signed_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    is_mop_d     = is_mop_q;
    o_memReq      = 1'b0;
    o_memWrite    = 1'b0;
    o_memIsFetch  = 1'b0;
    o_irWrite     = 1'b0;
    o_pcWrite     = 1'b0;
    o_regWrite    = 1'b0;
    o_mulDivStart = 1'b0;
    case (state_q)
      S_RST: begin
        tmo_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        o_memReq     = 1'b1;
        o_memIsFetch = 1'b1;
        if (i_memReady) begin
          o_irWrite = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo_hit) begin
          memtmo_d = 1'b1;
          state_d  = S_TRAP;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        alu_op_d     = dec_alu_op;
        alu_src_d    = dec_alu_src;
        imm_src_d    = dec_imm;
        result_src_d = dec_res;
        branch_d     = dec_br;
        jal_d        = dec_jal;
        jalr_d       = dec_jalr;
        signed_d     = i_funct3[2];
        is_load_d    = dec_load;
        is_store_d   = dec_store;
        is_mop_d     = dec_mop;
        if (dec_halt) begin
          halt_d  = 1'b1;
          state_d = S_HALT;
        end else if (dec_nop) begin
          o_pcWrite = 1'b1;
          tmo_d     = '0;
          state_d   = S_FETCH;
        end else if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          exec_first_d = 1'b1;
          exec_d       = dec_mop ? dec_lat_m1 : '0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        o_mulDivStart = is_mop_q && exec_first_q;
        if (exec_q != '0) begin
          exec_d = exec_q - CNT_W'(1);
        end else if (is_load_q || is_store_q) begin
          tmo_d   = '0;
          state_d = S_MEM;
        end else if (branch_q) begin
          o_pcWrite = 1'b1;
          tmo_d     = '0;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        o_memReq   = 1'b1;
        o_memWrite = is_store_q;
        if (i_memReady) begin
          if (is_store_q) begin
            o_pcWrite = 1'b1;
            tmo_d     = '0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          memtmo_d = 1'b1;
          state_d  = S_TRAP;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_WB: begin
        o_regWrite = 1'b1;
        o_pcWrite  = 1'b1;
        tmo_d      = '0;
        state_d    = S_FETCH;
      end
      default: state_d = state_q;  // HALT and TRAP are terminal
    endcase
  end

  // State and control-field registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_RST;
      tmo_q        <= '0;
      exec_q       <= '0;
      exec_first_q <= 1'b0;
      halt_q       <= 1'b0;
      illegal_q    <= 1'b0;
      memtmo_q     <= 1'b0;
      alu_op_q     <= 2'b00;
      alu_src_q    <= 1'b0;
      imm_src_q    <= 3'b000;
      result_src_q <= 2'b00;
      branch_q     <= 1'b0;
      jal_q        <= 1'b0;
      jalr_q       <= 1'b0;
      signed_q     <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      is_mop_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      exec_q       <= exec_d;
      exec_first_q <= exec_first_d;
      halt_q       <= halt_d;
      illegal_q    <= illegal_d;
      memtmo_q     <= memtmo_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      imm_src_q    <= imm_src_d;
      result_src_q <= result_src_d;
      branch_q     <= branch_d;
      jal_q        <= jal_d;
      jalr_q       <= jalr_d;
      signed_q     <= signed_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      is_mop_q     <= is_mop_d;
    end
  end

  assign o_ALUSrc       = alu_src_q;
  assign o_immSrc       = imm_src_q;
  assign o_resultSrc    = result_src_q;
  assign o_ALUOp        = alu_op_q;
  assign o_branch       = branch_q;
  assign o_jal          = jal_q;
  assign o_jalr         = jalr_q;
  assign o_isLoadSigned = signed_q;
  assign o_halt         = halt_q;
  assign o_illegal      = illegal_q;
  assign o_memTimeout   = memtmo_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl. Instance 0 uses the default parameters;
// instance 1 has ENABLE_M=0 and MEM_TIMEOUT=4. Both share the inputs, and
// the instance not under test is held in reset. Per-cycle expectations are
// queued as each instruction is planned and popped as cycles complete.
module tb_multicycle_main_ctrl;

  localparam logic [2:0] ST_RST = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_TRAP = 3'd7;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       rdy;

  logic [1:0] req_w, wr_w, isf_w, irw_w, pcw_w, rgw_w, asrc_w;
  logic [1:0] br_w, jal_w, jalr_w, sgn_w, mds_w, halt_w, ill_w, tmo_w;
  logic [2:0] imm_w [2];
  logic [1:0] res_w [2];
  logic [1:0] aop_w [2];
  logic [2:0] st_w  [2];

  typedef struct {
    string      tag;
    logic       rdy;
    logic [9:0] exp;
  } cyc_t;

  cyc_t sb_q[$];
  int   sel;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  multicycle_main_ctrl #(
    .ENABLE_M(1'b1), .MUL_LATENCY(2), .DIV_LATENCY(32), .MEM_TIMEOUT(255)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_opcode(opcode), .i_funct3(f3),
    .i_funct7(f7), .i_memReady(rdy),
    .o_memReq(req_w[0]), .o_memWrite(wr_w[0]), .o_memIsFetch(isf_w[0]),
    .o_irWrite(irw_w[0]), .o_pcWrite(pcw_w[0]), .o_regWrite(rgw_w[0]),
    .o_ALUSrc(asrc_w[0]), .o_immSrc(imm_w[0]), .o_resultSrc(res_w[0]),
    .o_ALUOp(aop_w[0]), .o_branch(br_w[0]), .o_jal(jal_w[0]), .o_jalr(jalr_w[0]),
    .o_isLoadSigned(sgn_w[0]), .o_mulDivStart(mds_w[0]), .o_halt(halt_w[0]),
    .o_illegal(ill_w[0]), .o_memTimeout(tmo_w[0]), .o_state(st_w[0])
  );

  multicycle_main_ctrl #(
    .ENABLE_M(1'b0), .MUL_LATENCY(2), .DIV_LATENCY(32), .MEM_TIMEOUT(4)
  ) u_dut_nom (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_opcode(opcode), .i_funct3(f3),
    .i_funct7(f7), .i_memReady(rdy),
    .o_memReq(req_w[1]), .o_memWrite(wr_w[1]), .o_memIsFetch(isf_w[1]),
    .o_irWrite(irw_w[1]), .o_pcWrite(pcw_w[1]), .o_regWrite(rgw_w[1]),
    .o_ALUSrc(asrc_w[1]), .o_immSrc(imm_w[1]), .o_resultSrc(res_w[1]),
    .o_ALUOp(aop_w[1]), .o_branch(br_w[1]), .o_jal(jal_w[1]), .o_jalr(jalr_w[1]),
    .o_isLoadSigned(sgn_w[1]), .o_mulDivStart(mds_w[1]), .o_halt(halt_w[1]),
    .o_illegal(ill_w[1]), .o_memTimeout(tmo_w[1]), .o_state(st_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {state, req, write, isFetch, irWrite, pcWrite, regWrite, mulDivStart}
  function automatic logic [9:0] obs_cyc();
    return {st_w[sel], req_w[sel], wr_w[sel], isf_w[sel], irw_w[sel],
            pcw_w[sel], rgw_w[sel], mds_w[sel]};
  endfunction

  // {ALUOp, ALUSrc, immSrc, resultSrc, branch, jal, jalr, isLoadSigned}
  function automatic logic [11:0] obs_fields();
    return {aop_w[sel], asrc_w[sel], imm_w[sel], res_w[sel],
            br_w[sel], jal_w[sel], jalr_w[sel], sgn_w[sel]};
  endfunction

  function automatic logic [2:0] obs_flags();
    return {halt_w[sel], ill_w[sel], tmo_w[sel]};
  endfunction

  task automatic push(input string tag, input logic r, input logic [2:0] st,
                      input logic req, input logic wr, input logic isf,
                      input logic irw, input logic pcw, input logic rgw, input logic mds);
    cyc_t e;
    e.tag = tag;
    e.rdy = r;
    e.exp = {st, req, wr, isf, irw, pcw, rgw, mds};
    sb_q.push_back(e);
  endtask

  // Pop one entry per cycle: drive its ready, compare mid-cycle
  task automatic drain();
    cyc_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      rdy = e.rdy;
      @(negedge clk);
      check(e.tag, 32'(obs_cyc()), 32'(e.exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int w);
    sel = w;
    rst_n[w] = 1'b0;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("rst%0d.cyc", w), 32'(obs_cyc()), 32'd0);
    check($sformatf("rst%0d.fields", w), 32'(obs_fields()), 32'd0);
    check($sformatf("rst%0d.flags", w), 32'(obs_flags()), 32'd0);
    rst_n[w] = 1'b1;
    push("rst.release", 1'b1, ST_RST, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Plan one instruction from its opcode class, run it, check the fields.
  // term != 0 names the terminal state expected right after DECODE.
  task automatic do_instr(input string nm, input logic [6:0] op, input logic [2:0] fn3,
                          input logic [6:0] fn7, input int fw, input int mw,
                          input logic [11:0] ef, input int term);
    bit is_ld, is_st, is_br, mop, nop;
    int ex_n;
    opcode = op;
    f3 = fn3;
    f7 = fn7;
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    is_br = (op == 7'b1100011);
    mop   = (sel == 0) && (op == 7'b0110011) && (fn7 == 7'b0000001);
    nop   = (op == 7'b0000000) || (op == 7'b1110011 && fn3 != 3'b000);
    ex_n  = mop ? (fn3[2] ? 32 : 2) : 1;
    for (int i = 0; i < fw; i++) push({nm, ".fwait"}, 1'b0, ST_F, 1, 0, 1, 0, 0, 0, 0);
    push({nm, ".fetch"}, 1'b1, ST_F, 1, 0, 1, 1, 0, 0, 0);
    push({nm, ".decode"}, 1'b1, ST_D, 0, 0, 0, 0, nop, 0, 0);
    if (term != 0) begin
      for (int i = 0; i < 50; i++) push({nm, ".term"}, 1'b1, 3'(term), 0, 0, 0, 0, 0, 0, 0);
    end else if (!nop) begin
      for (int i = 0; i < ex_n; i++)
        push({nm, ".exec"}, 1'b1, ST_E, 0, 0, 0, 0, is_br && (i == ex_n - 1), 0, mop && (i == 0));
      if (!is_br) begin
        if (is_ld || is_st) begin
          for (int i = 0; i < mw; i++) push({nm, ".mwait"}, 1'b0, ST_M, 1, is_st, 0, 0, 0, 0, 0);
          push({nm, ".mem"}, 1'b1, ST_M, 1, is_st, 0, 0, is_st, 0, 0);
        end
        if (!is_st) push({nm, ".wb"}, 1'b1, ST_WB, 0, 0, 0, 0, 1, 1, 0);
      end
    end
    drain();
    if (term == 0 && !nop) check({nm, ".fields"}, 32'(obs_fields()), 32'(ef));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d done", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 2'b11;
    rdy = 1'b0;
    opcode = 7'b0;
    f3 = 3'b0;
    f7 = 7'b0;
    sel = 0;
    #1 rst_n = 2'b00;

    do_reset(0);
    do_instr("add",   7'b0110011, 3'b000, 7'b0000000, 0, 0, 12'b10_0_000_00_000_0, 0);
    do_instr("sub",   7'b0110011, 3'b000, 7'b0100000, 0, 0, 12'b10_0_000_00_000_0, 0);
    do_instr("lw",    7'b0000011, 3'b010, 7'b0000000, 3, 2, 12'b00_1_000_01_000_0, 0);
    do_instr("lbu",   7'b0000011, 3'b100, 7'b0000000, 0, 0, 12'b00_1_000_01_000_1, 0);
    do_instr("sw",    7'b0100011, 3'b010, 7'b0000000, 0, 0, 12'b00_1_011_00_000_0, 0);
    do_instr("slli",  7'b0010011, 3'b001, 7'b0000000, 0, 0, 12'b10_1_010_00_000_0, 0);
    do_instr("addi",  7'b0010011, 3'b000, 7'b0000000, 0, 0, 12'b10_1_001_00_000_0, 0);
    do_instr("srai",  7'b0010011, 3'b101, 7'b0100000, 0, 0, 12'b10_1_010_00_000_1, 0);
    do_instr("lui",   7'b0110111, 3'b000, 7'b0000000, 0, 0, 12'b00_0_100_10_000_0, 0);
    do_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, 0, 0, 12'b00_0_100_10_000_0, 0);
    do_instr("beq",   7'b1100011, 3'b000, 7'b0000000, 0, 0, 12'b01_0_101_00_100_0, 0);
    do_instr("bltu",  7'b1100011, 3'b110, 7'b0000000, 0, 0, 12'b01_0_101_00_100_1, 0);
    do_instr("jalr",  7'b1100111, 3'b000, 7'b0000000, 0, 0, 12'b00_0_110_11_001_0, 0);
    do_instr("jal",   7'b1101111, 3'b000, 7'b0000000, 0, 0, 12'b00_0_111_11_010_0, 0);
    do_instr("mul",   7'b0110011, 3'b000, 7'b0000001, 0, 0, 12'b10_0_000_00_000_0, 0);
    do_instr("div",   7'b0110011, 3'b100, 7'b0000001, 1, 0, 12'b10_0_000_00_000_1, 0);
    do_instr("nop0",  7'b0000000, 3'b000, 7'b0000000, 0, 0, 12'b0, 0);
    do_instr("csr",   7'b1110011, 3'b001, 7'b0000000, 0, 0, 12'b0, 0);
    // ready on the very cycle the 255-cycle limit is reached must win
    do_instr("lw_edge", 7'b0000011, 3'b010, 7'b0000000, 254, 0, 12'b00_1_000_01_000_0, 0);
    do_instr("sw_edge", 7'b0100011, 3'b000, 7'b0000000, 0, 254, 12'b00_1_011_00_000_0, 0);
    check("main.flags_clean", 32'(obs_flags()), 32'd0);

    // Reset asserted while a store waits in MEM
    opcode = 7'b0100011;
    f3 = 3'b010;
    f7 = 7'b0;
    push("midmem.fetch", 1'b1, ST_F, 1, 0, 1, 1, 0, 0, 0);
    push("midmem.decode", 1'b1, ST_D, 0, 0, 0, 0, 0, 0, 0);
    push("midmem.exec", 1'b1, ST_E, 0, 0, 0, 0, 0, 0, 0);
    push("midmem.mwait", 1'b0, ST_M, 1, 1, 0, 0, 0, 0, 0);
    drain();
    rdy = 1'b0;
    #2;
    check("midmem.req_before", 32'(req_w[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    check("midmem.req_after", 32'(req_w[0]), 32'd0);
    check("midmem.state_after", 32'(st_w[0]), 32'(ST_RST));

    do_reset(0);
    do_instr("ecall", 7'b1110011, 3'b000, 7'b0000000, 0, 0, 12'b0, ST_HALT);
    check("ecall.flags", 32'(obs_flags()), 32'b100);
    do_reset(0);
    do_instr("bad_op", 7'b1111111, 3'b000, 7'b0000000, 0, 0, 12'b0, ST_TRAP);
    check("bad_op.flags", 32'(obs_flags()), 32'b010);
    do_reset(0);
    do_instr("bad_f7", 7'b0110011, 3'b000, 7'b0100001, 0, 0, 12'b0, ST_TRAP);
    check("bad_f7.flags", 32'(obs_flags()), 32'b010);
    rst_n[0] = 1'b0;

    // Instance with no M extension and a 4-cycle memory timeout
    do_reset(1);
    do_instr("nom.add_edge", 7'b0110011, 3'b000, 7'b0000000, 3, 0, 12'b10_0_000_00_000_0, 0);
    do_instr("nom.div", 7'b0110011, 3'b100, 7'b0000001, 0, 0, 12'b0, ST_TRAP);
    check("nom.div.flags", 32'(obs_flags()), 32'b010);
    do_reset(1);
    for (int i = 0; i < 4; i++) push("tmo.fwait", 1'b0, ST_F, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) push("tmo.trap", 1'b0, ST_TRAP, 0, 0, 0, 0, 0, 0, 0);
    drain();
    check("tmo.flags", 32'(obs_flags()), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
